// File: rtl/palette_pkg.sv
// palette_pkg: shared constants, entry type and fade helper for the palette
// writer front end.
//   REG_*        CPU register select codes
//   PAL_*_W      palette index / colour widths
//   pal_entry_t  one queued palette write {idx, rgb}
//   fade_next    one saturating fade step toward a target brightness
package palette_pkg;

  localparam logic [1:0] REG_INDEX = 2'd0;
  localparam logic [1:0] REG_LO    = 2'd1;
  localparam logic [1:0] REG_HI    = 2'd2;
  localparam logic [1:0] REG_FADE  = 2'd3;

  localparam int PAL_IDX_W = 8;
  localparam int PAL_RGB_W = 24;

  typedef struct packed {
    logic [PAL_IDX_W-1:0] idx;
    logic [PAL_RGB_W-1:0] rgb;
  } pal_entry_t;

  // Step cur toward tgt by stp without crossing tgt; stp==0 snaps to tgt.
  // Sums are formed in 9 bits so nothing wraps past 255 or below 0.
  function automatic logic [7:0] fade_next(input logic [7:0] cur,
                                           input logic [7:0] tgt,
                                           input logic [7:0] stp);
    logic [8:0] w_sum;
    logic [8:0] w_lim;
    logic [7:0] res;
    w_sum = {1'b0, cur} + {1'b0, stp};
    w_lim = {1'b0, tgt} + {1'b0, stp};
    res   = cur;
    if (stp == 8'd0)
      res = tgt;
    else if (cur < tgt)
      res = (w_sum >= {1'b0, tgt}) ? tgt : w_sum[7:0];
    else if (cur > tgt)
      res = ({1'b0, cur} <= w_lim) ? tgt : (cur - stp);
    return res;
  endfunction

endpackage

// File: rtl/palette_loader_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head.
//   clk, reset_n        clock, async active-low reset (empties the FIFO)
//   push, push_data     write request; accepted when not full, or when a pop
//                       frees a slot in the same cycle
//   pop, pop_data       pop request (ignored when empty); pop_data is the head
//   count, full, empty  occupancy status
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty;
  // A full FIFO still takes a push if the head leaves in the same cycle.
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/palette_loader.sv
// palette_loader: CPU-side writer for the VGA palette.
//   clk, reset_n                 clock, async active-low reset
//   cpu_wr/cpu_addr/cpu_data     register writes: INDEX, LO (G,B), HI (R, push), FADE
//   vblank                       level; queued entries only drain while high
//   wrindex/write/data           palette write port, one entry per cycle
//   brightness                   per-frame faded brightness
//   fifo_count, overflow, busy   status (overflow is sticky until INDEX write)
module palette_loader
  import palette_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] BRIGHT_RESET = 8'd0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cpu_wr,
  input  logic [1:0]                    cpu_addr,
  input  logic [15:0]                   cpu_data,
  input  logic                          vblank,
  output logic [PAL_IDX_W-1:0]          wrindex,
  output logic                          write,
  output logic [PAL_RGB_W-1:0]          data,
  output logic [7:0]                    brightness,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  logic [PAL_IDX_W-1:0] r_index;
  logic [15:0]          r_hold;
  logic [7:0]           r_target;
  logic [7:0]           r_step;
  logic                 r_vb_prev;

  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_rise;
  pal_entry_t w_push_entry;
  pal_entry_t w_head;

  assign w_push       = cpu_wr && (cpu_addr == REG_HI);
  // Pop only while blanking so the visible frame never sees a colour change.
  assign w_pop        = vblank && !w_empty;
  assign w_rise       = vblank && !r_vb_prev;
  assign w_push_entry = '{idx: r_index, rgb: {cpu_data[7:0], r_hold}};
  assign busy         = (fifo_count != '0) || write;

  sync_fifo #(
    .WIDTH ($bits(pal_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrindex    <= '0;
      write      <= 1'b0;
      data       <= '0;
      brightness <= BRIGHT_RESET;
      overflow   <= 1'b0;
      r_index    <= '0;
      r_hold     <= '0;
      r_target   <= BRIGHT_RESET;
      r_step     <= '0;
      r_vb_prev  <= 1'b0;
    end else begin
      r_vb_prev <= vblank;
      write     <= w_pop;
      if (w_pop) begin
        wrindex <= w_head.idx;
        data    <= w_head.rgb;
      end
      // Fade uses the target/step held before any same-cycle FADE write.
      if (w_rise) brightness <= fade_next(brightness, r_target, r_step);
      if (cpu_wr) begin
        case (cpu_addr)
          REG_INDEX: r_index <= cpu_data[7:0];
          REG_LO:    r_hold  <= cpu_data;
          REG_HI:    r_index <= r_index + 1'b1;  // advances even if dropped
          REG_FADE: begin
            r_target <= cpu_data[7:0];
            r_step   <= cpu_data[15:8];
          end
          default: ;
        endcase
      end
      if (cpu_wr && (cpu_addr == REG_INDEX))
        overflow <= 1'b0;
      else if (w_push && w_full && !w_pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
module tb_palette_loader;

  localparam int         DEPTH = 16;
  localparam logic [7:0] BRST  = 8'd0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_wr;
  logic [1:0]  cpu_addr;
  logic [15:0] cpu_data;
  logic        vblank;
  logic [7:0]  wrindex;
  logic        write;
  logic [23:0] data;
  logic [7:0]  brightness;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  palette_loader #(.FIFO_DEPTH(DEPTH), .BRIGHT_RESET(BRST)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .vblank(vblank), .wrindex(wrindex), .write(write),
    .data(data), .brightness(brightness), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [7:0]  m_idx;
  logic [15:0] m_hold;
  logic [7:0]  m_tgt, m_stp, m_bri;
  logic        m_vbp, m_ovf, m_wr;
  logic [31:0] m_out;

  function automatic logic [7:0] fade_model(int b, int t, int s);
    if (s == 0) return 8'(t);
    if (b < t)  return (b + s > t) ? 8'(t) : 8'(b + s);
    if (b > t)  return (b - s < t) ? 8'(t) : 8'(b - s);
    return 8'(b);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_idx = 0; m_hold = 0; m_tgt = BRST; m_stp = 0; m_bri = BRST;
    m_vbp = 0; m_ovf = 0; m_wr = 0; m_out = 0;
  endtask

  // One clock: drive inputs, wait for the edge, advance the model.
  task automatic tick(input logic wr, input logic [1:0] a,
                      input logic [15:0] d, input logic vb);
    logic pop, full;
    cpu_wr = wr; cpu_addr = a; cpu_data = d; vblank = vb;
    @(posedge clk); #1;
    pop  = vb && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    if (pop) begin m_out = m_q.pop_front(); m_wr = 1; end
    else m_wr = 0;
    if (vb && !m_vbp) m_bri = fade_model(m_bri, m_tgt, m_stp);
    m_vbp = vb;
    if (wr) begin
      case (a)
        2'd0: begin m_idx = d[7:0]; m_ovf = 0; end
        2'd1: m_hold = d;
        2'd2: begin
          if (!full || pop) m_q.push_back({m_idx, d[7:0], m_hold});
          else m_ovf = 1;
          m_idx = m_idx + 8'd1;
        end
        default: begin m_tgt = d[7:0]; m_stp = d[15:8]; end
      endcase
    end
    cpu_wr = 0;
  endtask

  task automatic reset_dut();
    cpu_wr = 0; cpu_addr = 0; cpu_data = 0; vblank = 0;
    reset_n = 0; #3;
    model_reset();
    reset_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cpu_wr = 0; cpu_addr = 0; cpu_data = 0; vblank = 0;
    reset_n = 0;
    model_reset();
    #12;
    checks++; if (write !== 1'b0)     begin failures++; $display("FAIL reset_write got=%0b exp=0", write); end
    checks++; if (wrindex !== 8'h00)  begin failures++; $display("FAIL reset_wrindex got=%0h exp=0", wrindex); end
    checks++; if (data !== 24'h0)     begin failures++; $display("FAIL reset_data got=%0h exp=0", data); end
    checks++; if (brightness !== BRST) begin failures++; $display("FAIL reset_bright got=%0h exp=%0h", brightness, BRST); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    #1 reset_n = 1;
  endtask

  task automatic test_single();
    tick(1, 2'd0, 16'h0010, 1);
    tick(1, 2'd1, 16'h3456, 1);
    tick(1, 2'd2, 16'h0012, 1);   // edge N
    checks++; if (write !== 1'b0 || fifo_count !== 5'd1) begin failures++;
      $display("FAIL single_n1 write=%0b count=%0d exp write=0 count=1", write, fifo_count); end
    tick(0, 2'd0, 16'h0, 1);      // edge N+1: pop
    checks++; if (write !== 1'b1 || wrindex !== 8'h10 || data !== 24'h123456) begin failures++;
      $display("FAIL single_n2 write=%0b idx=%0h data=%0h exp 1/10/123456", write, wrindex, data); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", fifo_count); end
    tick(0, 2'd0, 16'h0, 1);
    checks++; if (write !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL single_after write=%0b busy=%0b exp 0/0", write, busy); end
  endtask

  task automatic test_deferred();
    logic [7:0] exp_idx [3];
    int k = 0;
    exp_idx[0] = 8'hFE; exp_idx[1] = 8'hFF; exp_idx[2] = 8'h00;
    reset_dut();
    tick(1, 2'd0, 16'h00FE, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 2'd1, 16'($urandom), 0);
      tick(1, 2'd2, 16'($urandom), 0);
    end
    tick(0, 2'd0, 16'h0, 0);
    checks++; if (fifo_count !== 5'd3 || write !== 1'b0) begin failures++;
      $display("FAIL deferred_hold count=%0d write=%0b exp 3/0", fifo_count, write); end
    for (int i = 0; i < 5; i++) begin
      tick(0, 2'd0, 16'h0, 1);
      checks++; if (write !== m_wr) begin failures++;
        $display("FAIL deferred_write cyc=%0d got=%0b exp=%0b", i, write, m_wr); end
      if (m_wr) begin
        checks++; if ({wrindex, data} !== m_out || k > 2 || wrindex !== exp_idx[k]) begin failures++;
          $display("FAIL deferred_entry k=%0d got=%0h exp=%0h", k, {wrindex, data}, m_out); end
        k++;
      end
    end
    checks++; if (k !== 3) begin failures++; $display("FAIL deferred_nwrites got=%0d exp=3", k); end
  endtask

  task automatic test_overflow();
    int n = 0;
    reset_dut();
    tick(1, 2'd0, 16'h0020, 0);
    tick(1, 2'd1, 16'hBEEF, 0);
    for (int i = 0; i < DEPTH + 1; i++) tick(1, 2'd2, 16'(i), 0);
    checks++; if (fifo_count !== 5'd16 || overflow !== 1'b1) begin failures++;
      $display("FAIL ovf_full count=%0d ovf=%0b exp 16/1", fifo_count, overflow); end
    // push into full FIFO with a simultaneous pop is accepted
    tick(1, 2'd2, 16'h00AA, 1);
    checks++; if (fifo_count !== 5'(m_q.size()) || fifo_count !== 5'd16 || write !== 1'b1) begin failures++;
      $display("FAIL ovf_pushpop count=%0d write=%0b exp 16/1", fifo_count, write); end
    checks++; if (wrindex !== 8'h20) begin failures++; $display("FAIL ovf_first got=%0h exp=20", wrindex); end
    tick(1, 2'd0, 16'h0000, 0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick(0, 2'd0, 16'h0, 1);
      if (m_wr) begin
        n++;
        checks++; if (write !== 1'b1 || {wrindex, data} !== m_out) begin failures++;
          $display("FAIL ovf_drain i=%0d got=%0h exp=%0h", i, {wrindex, data}, m_out); end
      end
    end
    checks++; if (n !== 16 || fifo_count !== 5'd0) begin failures++;
      $display("FAIL ovf_ndrain got=%0d count=%0d exp 16/0", n, fifo_count); end
  endtask

  task automatic test_vblank_drop();
    int n = 0;
    reset_dut();
    tick(1, 2'd0, 16'h0040, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 2'd1, 16'($urandom), 0);
      tick(1, 2'd2, 16'($urandom), 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 2'd0, 16'h0, (i < 3));
      if (write === 1'b1) n++;
    end
    checks++; if (n !== 3 || fifo_count !== 5'd5) begin failures++;
      $display("FAIL drop_partial writes=%0d count=%0d exp 3/5", n, fifo_count); end
    for (int i = 0; i < 8; i++) begin
      tick(0, 2'd0, 16'h0, 1);
      checks++; if (write !== m_wr || (m_wr && {wrindex, data} !== m_out)) begin failures++;
        $display("FAIL drop_resume i=%0d got=%0b/%0h exp=%0b/%0h", i, write, {wrindex, data}, m_wr, m_out); end
    end
    checks++; if (wrindex !== 8'h47) begin failures++; $display("FAIL drop_last got=%0h exp=47", wrindex); end
  endtask

  task automatic test_fade();
    int e;
    reset_dut();
    tick(1, 2'd3, 16'h0350, 0);
    checks++; if (brightness !== 8'h00) begin failures++; $display("FAIL fade_nochange got=%0h exp=0", brightness); end
    for (int k = 1; k <= 30; k++) begin
      tick(0, 2'd0, 16'h0, 1);
      e = (3 * k > 'h50) ? 'h50 : 3 * k;
      checks++; if (brightness !== 8'(e) || brightness !== m_bri) begin failures++;
        $display("FAIL fade_up k=%0d got=%0h exp=%0h", k, brightness, e); end
      tick(0, 2'd0, 16'h0, 0);
    end
    // FADE write coinciding with a rising edge: old step/target apply this frame
    tick(1, 2'd3, 16'h0000, 1);
    checks++; if (brightness !== 8'h50) begin failures++; $display("FAIL fade_sameedge got=%0h exp=50", brightness); end
    tick(0, 2'd0, 16'h0, 0);
    tick(0, 2'd0, 16'h0, 1);
    checks++; if (brightness !== 8'h00) begin failures++; $display("FAIL fade_snap got=%0h exp=0", brightness); end
    // fade down from 0xF0 by 0x30 toward 0x10: F0 C0 90 60 30 10 10
    tick(1, 2'd3, 16'h00F0, 0);
    tick(0, 2'd0, 16'h0, 1);
    tick(1, 2'd3, 16'h3010, 0);
    for (int k = 1; k <= 6; k++) begin
      tick(0, 2'd0, 16'h0, 1);
      e = (240 - 48 * k < 16) ? 16 : 240 - 48 * k;
      checks++; if (brightness !== 8'(e)) begin failures++; $display("FAIL fade_down k=%0d got=%0h exp=%0h", k, brightness, e); end
      tick(0, 2'd0, 16'h0, 0);
    end
  endtask

  task automatic test_random();
    logic vb = 0;
    int errs = 0;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) vb = ~vb;
      tick(logic'($urandom_range(1)), 2'($urandom), 16'($urandom), vb);
      checks++;
      if (write !== m_wr || (m_wr && {wrindex, data} !== m_out) ||
          fifo_count !== 5'(m_q.size()) || overflow !== m_ovf ||
          brightness !== m_bri || busy !== ((m_q.size() != 0) || m_wr)) begin
        failures++; errs++;
        if (errs < 10)
          $display("FAIL random i=%0d w=%0b/%0b e=%0h/%0h c=%0d/%0d o=%0b/%0b b=%0h/%0h", i,
                   write, m_wr, {wrindex, data}, m_out, fifo_count, m_q.size(),
                   overflow, m_ovf, brightness, m_bri);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    tick(1, 2'd3, 16'h0040, 0);
    tick(0, 2'd0, 16'h0, 1);
    tick(0, 2'd0, 16'h0, 0);
    tick(1, 2'd0, 16'h0001, 0);
    for (int i = 0; i < 4; i++) tick(1, 2'd2, 16'($urandom), 0);
    tick(0, 2'd0, 16'h0, 1);
    checks++; if (write !== 1'b1 || fifo_count !== 5'd3 || brightness !== 8'h40) begin failures++;
      $display("FAIL areset_pre write=%0b count=%0d bright=%0h exp 1/3/40", write, fifo_count, brightness); end
    #2 reset_n = 0;
    #1;
    checks++; if (write !== 1'b0 || fifo_count !== 5'd0 || brightness !== BRST || busy !== 1'b0) begin failures++;
      $display("FAIL areset write=%0b count=%0d bright=%0h busy=%0b exp 0/0/%0h/0", write, fifo_count, brightness, busy, BRST); end
    #1 reset_n = 1;
    model_reset();
    tick(0, 2'd0, 16'h0, 1);
    checks++; if (write !== 1'b0 || fifo_count !== 5'd0) begin failures++;
      $display("FAIL areset_after write=%0b count=%0d exp 0/0", write, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_deferred();
    test_overflow();
    test_vblank_drop();
    test_fade();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
